// File: rtl/mem_responder.sv
// mem_responder: single-port memory slave answering one read or write at a time.
// Latency: accept in IDLE at cycle N, response pulse at N+1+WAIT_CYCLES, next accept at N+2+WAIT_CYCLES.
// Backpressure: requests are level signals held by the requester until the completion pulse.
//
// Ports:
//   clk_i, reset_i                    clock and synchronous active-high reset
//   rd_req_i/rd_addr_i/rd_size_i      read request (size 0 byte, 1 half, 2 word, 3 reserved)
//   rd_data_o/rd_valid_o              read data (zero-extended, right-aligned) and completion pulse
//   wr_req_i/wr_addr_i/wr_size_i/wr_data_i  write request
//   wr_done_o                         write completion pulse
//   busy_o                            high while a transaction is in flight
//   err_o                             error pulse coincident with the failing completion
// Build option: define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned half/word accesses
// as errors; otherwise misaligned addresses are truncated to natural alignment.

module mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h00010000,
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rd_req_i,
   input  logic [31:0] rd_addr_i,
   input  logic [1:0]  rd_size_i,
   output logic [31:0] rd_data_o,
   output logic        rd_valid_o,
   input  logic        wr_req_i,
   input  logic [31:0] wr_addr_i,
   input  logic [1:0]  wr_size_i,
   input  logic [31:0] wr_data_i,
   output logic        wr_done_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_nxt;
   logic [3:0]  cnt_q, cnt_nxt;
   logic        capture;

   // Request fields frozen at accept; the access only ever uses these.
   logic        req_wr_q;
   logic [31:0] req_addr_q;
   logic [1:0]  req_size_q;
   logic [31:0] req_data_q;

   logic [31:0] rd_hold_q;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic [31:0]      offset;
   logic [IDX_W-1:0] word_idx;
   logic [1:0]       lane;
   logic             in_range;
   logic             misalign;
   logic             acc_err;
   logic [31:0]      mem_word;
   logic [31:0]      rd_now;
   logic [31:0]      wr_word;

   // Address decode and lane handling on the captured request.
   always_comb begin
      offset   = req_addr_q - BASE_ADDR;
      word_idx = IDX_W'(offset >> 2);
      lane     = req_addr_q[1:0];
      in_range = ({1'b0, req_addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, req_addr_q} < END_ADDR);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      misalign = ((req_size_q == 2'd1) && lane[0]) || ((req_size_q == 2'd2) && (lane != 2'd0));
`else
      misalign = 1'b0;
`endif
      acc_err  = !in_range || (req_size_q == 2'd3) || misalign;
      mem_word = mem_q[word_idx];

      rd_now  = 32'd0;
      wr_word = mem_word;
      case (req_size_q)
         2'd0: begin
            rd_now[7:0] = mem_word[{lane, 3'b000} +: 8];
            wr_word[{lane, 3'b000} +: 8] = req_data_q[7:0];
         end
         2'd1: begin
            // Half accesses ignore addr[0]: lane pair {addr[1],0}/{addr[1],1}.
            rd_now[15:0] = mem_word[{lane[1], 4'b0000} +: 16];
            wr_word[{lane[1], 4'b0000} +: 16] = req_data_q[15:0];
         end
         2'd2: begin
            rd_now  = mem_word;
            wr_word = req_data_q;
         end
         default: begin
            rd_now  = 32'd0;
            wr_word = mem_word;
         end
      endcase
      if (acc_err) begin
         rd_now = 32'd0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_req_i || rd_req_i) begin
               capture   = 1'b1;
               cnt_nxt   = WAIT_LOAD;
               state_nxt = (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The cycle that sees a count of 1 is the last wait state.
            if (cnt_q != 4'd0) begin
               cnt_nxt = cnt_q - 4'd1;
            end
            if (cnt_q <= 4'd1) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         req_wr_q   <= 1'b0;
         req_addr_q <= 32'd0;
         req_size_q <= 2'd0;
         req_data_q <= 32'd0;
         rd_hold_q  <= 32'd0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         if (capture) begin
            // A simultaneous read stays pending and is taken on the next IDLE cycle.
            req_wr_q   <= wr_req_i;
            req_addr_q <= wr_req_i ? wr_addr_i : rd_addr_i;
            req_size_q <= wr_req_i ? wr_size_i : rd_size_i;
            req_data_q <= wr_data_i;
         end
         if ((state_q == ST_RESP) && !req_wr_q) begin
            rd_hold_q <= rd_now;
         end
      end
   end

   // Array is intentionally not reset; a reset in RESP drops the commit.
   always_ff @(posedge clk_i) begin
      if (!reset_i && (state_q == ST_RESP) && req_wr_q && !acc_err) begin
         mem_q[word_idx] <= wr_word;
      end
   end

   assign rd_valid_o = (state_q == ST_RESP) && !req_wr_q;
   assign wr_done_o  = (state_q == ST_RESP) && req_wr_q;
   assign err_o      = (state_q == ST_RESP) && acc_err;
   assign busy_o     = (state_q != ST_IDLE);
   // During a read response the fresh value is shown directly so WAIT_CYCLES=0 works too.
   assign rd_data_o  = rd_valid_o ? rd_now : rd_hold_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam logic [31:0] BASE  = 32'h00010000;
   localparam int unsigned DEPTH = 16384;
   localparam int unsigned WAITC = 2;
   localparam logic [31:0] ENDA  = BASE + 32'(DEPTH * 4);

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        rd_req_i;
   logic [31:0] rd_addr_i;
   logic [1:0]  rd_size_i;
   logic [31:0] rd_data_o;
   logic        rd_valid_o;
   logic        wr_req_i;
   logic [31:0] wr_addr_i;
   logic [1:0]  wr_size_i;
   logic [31:0] wr_data_i;
   logic        wr_done_o;
   logic        busy_o;
   logic        err_o;

   int n_chk  = 0;
   int n_fail = 0;

   // Byte-addressed reference memory and last read value seen on rd_data_o.
   logic [7:0]  mb [bit [31:0]];
   logic [31:0] last_rd;

   mem_responder #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(WAITC)
   ) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .rd_req_i  (rd_req_i),
      .rd_addr_i (rd_addr_i),
      .rd_size_i (rd_size_i),
      .rd_data_o (rd_data_o),
      .rd_valid_o(rd_valid_o),
      .wr_req_i  (wr_req_i),
      .wr_addr_i (wr_addr_i),
      .wr_size_i (wr_size_i),
      .wr_data_i (wr_data_i),
      .wr_done_o (wr_done_o),
      .busy_o    (busy_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
      bit e;
      e = (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(ENDA)) || (sz == 2'd3);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      if (sz == 2'd1 && (a % 2) != 0) e = 1'b1;
      if (sz == 2'd2 && (a % 4) != 0) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [31:0] m_align(input logic [31:0] a, input logic [1:0] sz);
      int unsigned n;
      n = 1 << sz;
      return a - (a % n);
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] al;
      if (m_err(a, sz)) return;
      al = m_align(a, sz);
      for (int i = 0; i < (1 << sz); i++) mb[al + 32'(i)] = d[8*i +: 8];
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] al, r;
      r = 32'd0;
      if (m_err(a, sz)) return r;
      al = m_align(a, sz);
      for (int i = 0; i < (1 << sz); i++) begin
         if (mb.exists(al + 32'(i))) r = r | (32'(mb[al + 32'(i)]) << (8 * i));
         else r = 32'hxxxxxxxx;
      end
      return r;
   endfunction

   // One transaction, called and returning just after a rising edge.
   task automatic txn(input string tag, input bit wr, input logic [31:0] a,
                      input logic [1:0] sz, input logic [31:0] d);
      int lat;
      logic [31:0] exp_rd;
      bit exp_err;
      exp_err = m_err(a, sz);
      exp_rd  = m_read(a, sz);
      if (wr) begin
         wr_req_i = 1'b1; wr_addr_i = a; wr_size_i = sz; wr_data_i = d;
      end else begin
         rd_req_i = 1'b1; rd_addr_i = a; rd_size_i = sz;
      end
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!(rd_valid_o || wr_done_o) && lat < 40);
      chk({tag, " latency"}, 32'(lat), 32'(WAITC + 2));
      chk({tag, " pulse"}, {30'd0, rd_valid_o, wr_done_o}, wr ? 32'd1 : 32'd2);
      chk({tag, " err"}, {31'd0, err_o}, {31'd0, exp_err});
      chk({tag, " busy"}, {31'd0, busy_o}, 32'd1);
      if (wr) begin
         chk({tag, " rd_data hold"}, rd_data_o, last_rd);
         m_write(a, sz, d);
      end else begin
         chk({tag, " rd_data"}, rd_data_o, exp_rd);
         last_rd = exp_rd;
      end
      @(posedge clk_i);
      #1;
      wr_req_i = 1'b0;
      rd_req_i = 1'b0;
   endtask

   initial begin
      int lat;
      bit saw;
      logic [31:0] a, d;
      logic [1:0]  sz;
      reset_i = 1'b1; rd_req_i = 1'b0; wr_req_i = 1'b0;
      rd_addr_i = 32'd0; rd_size_i = 2'd0; wr_addr_i = 32'd0; wr_size_i = 2'd0; wr_data_i = 32'd0;
      last_rd = 32'd0;
      repeat (3) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("reset outputs", {rd_valid_o, wr_done_o, err_o, busy_o, 28'd0}, 32'd0);
      chk("reset rd_data", rd_data_o, 32'd0);
      @(posedge clk_i);
      #1;

      // Basic word write/read and byte/half lanes.
      txn("w word", 1'b1, BASE, 2'd2, 32'hDEADBEEF);
      txn("r word", 1'b0, BASE, 2'd2, 32'd0);
      txn("w byte2", 1'b1, BASE + 32'd2, 2'd0, 32'hFFFFFF5A);
      txn("r word2", 1'b0, BASE, 2'd2, 32'd0);
      chk("merged word", last_rd, 32'hDE5ABEEF);
      txn("r half2", 1'b0, BASE + 32'd2, 2'd1, 32'd0);
      chk("half value", last_rd, 32'h0000DE5A);

      // Write and read raised together: write first, one IDLE cycle, then read.
      wr_req_i = 1'b1; wr_addr_i = BASE; wr_size_i = 2'd2; wr_data_i = 32'h12345678;
      rd_req_i = 1'b1; rd_addr_i = BASE; rd_size_i = 2'd2;
      lat = 0;
      do begin @(negedge clk_i); lat++; end while (!wr_done_o && lat < 40);
      chk("simul wr latency", 32'(lat), 32'(WAITC + 2));
      chk("simul no rd yet", {31'd0, rd_valid_o}, 32'd0);
      m_write(BASE, 2'd2, 32'h12345678);
      @(posedge clk_i); #1; wr_req_i = 1'b0;
      @(negedge clk_i);
      chk("simul idle gap", {31'd0, busy_o}, 32'd0);
      lat = 0; saw = 1'b0;
      do begin
         @(negedge clk_i); lat++;
         if (!busy_o) saw = 1'b1;
      end while (!rd_valid_o && lat < 40);
      chk("simul rd latency", 32'(lat), 32'(WAITC + 1));
      chk("simul busy held", {31'd0, saw}, 32'd0);
      chk("simul rd data", rd_data_o, 32'h12345678);
      last_rd = 32'h12345678;
      @(posedge clk_i); #1; rd_req_i = 1'b0;

      // Out-of-range accesses.
      txn("r below base", 1'b0, 32'h0000FFFC, 2'd2, 32'd0);
      txn("w at end", 1'b1, ENDA, 2'd2, 32'hCAFEF00D);
      txn("r size3", 1'b0, BASE, 2'd3, 32'd0);
      txn("r unchanged", 1'b0, BASE, 2'd2, 32'd0);

      // Inputs changed and request dropped right after accept.
      txn("w init4", 1'b1, BASE + 32'd4, 2'd2, 32'h0BADF00D);
      wr_req_i = 1'b1; wr_addr_i = BASE; wr_size_i = 2'd2; wr_data_i = 32'hA5A5C3C3;
      @(negedge clk_i); @(posedge clk_i); #1;
      wr_req_i = 1'b0; wr_addr_i = BASE + 32'd4; wr_size_i = 2'd0; wr_data_i = 32'h11111111;
      lat = 0;
      do begin @(negedge clk_i); lat++; end while (!wr_done_o && lat < 40);
      chk("captured latency", 32'(lat), 32'(WAITC + 1));
      m_write(BASE, 2'd2, 32'hA5A5C3C3);
      @(posedge clk_i); #1;
      txn("r captured", 1'b0, BASE, 2'd2, 32'd0);
      txn("r untouched", 1'b0, BASE + 32'd4, 2'd2, 32'd0);

      // Reset during WAIT of a word write abandons it.
      wr_req_i = 1'b1; wr_addr_i = BASE; wr_size_i = 2'd2; wr_data_i = 32'h99990000;
      @(negedge clk_i); @(posedge clk_i); #1;
      reset_i = 1'b1; wr_req_i = 1'b0;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      last_rd = 32'd0;
      saw = 1'b0;
      repeat (6) begin @(negedge clk_i); if (wr_done_o || busy_o) saw = 1'b1; end
      chk("abandoned write", {31'd0, saw}, 32'd0);
      chk("rd_data after reset", rd_data_o, 32'd0);
      @(posedge clk_i); #1;
      txn("r old value", 1'b0, BASE, 2'd2, 32'd0);

      // Misaligned half read: error with alignment checking, lanes 0-1 without.
      txn("r half mis", 1'b0, BASE + 32'd1, 2'd1, 32'd0);

      // Randomized traffic over the first four words and the last word.
      for (int i = 0; i < 4; i++) txn("init", 1'b1, BASE + 32'(4*i), 2'd2, $urandom);
      txn("init last", 1'b1, ENDA - 32'd4, 2'd2, $urandom);
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0:       a = BASE - 32'($urandom_range(1, 8));
            1:       a = ENDA + 32'($urandom_range(0, 7));
            2, 3:    a = ENDA - 32'd4 + 32'($urandom_range(0, 3));
            default: a = BASE + 32'($urandom_range(0, 15));
         endcase
         sz = 2'($urandom_range(0, 3));
         d  = $urandom;
         txn("rand", 1'($urandom_range(0, 1)), a, sz, d);
      end
      for (int i = 0; i < 4; i++) txn("final", 1'b0, BASE + 32'(4*i), 2'd2, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
